// File: rtl/serial_iot_sequencer_pkg.sv
// Shared encodings for the serial console IOT sequencer: major-state codes,
// sequencer op codes and PDP-8 IOT word construction.
package serial_iot_sequencer_pkg;

    // Major-state code of the IOT execution slot.
    localparam logic [4:0] F1 = 5'd1;

    // Sequencer ops; each one is the IOT currently presented to the serial block.
    localparam logic [2:0] OP_PRIME = 3'd0;
    localparam logic [2:0] OP_TSF   = 3'd1;
    localparam logic [2:0] OP_TLS   = 3'd2;
    localparam logic [2:0] OP_KSF   = 3'd3;
    localparam logic [2:0] OP_KRB   = 3'd4;
    localparam logic [2:0] OP_NOP   = 3'd5;

    localparam logic [2:0]  IOT_MAJOR   = 3'o6;
    localparam logic [2:0]  IOT_FN_SKIP = 3'o1;
    localparam logic [2:0]  IOT_FN_XFER = 3'o6;
    localparam logic [11:0] NOP_WORD    = 12'o7000;

    function automatic logic [11:0] iot_word(input logic [5:0] dev, input logic [2:0] fn);
        return {IOT_MAJOR, dev, fn};
    endfunction

endpackage

// File: rtl/serial_iot_sequencer_char_fifo.sv
// Synchronous 8-bit character FIFO with full/empty flags and a look-ahead
// non-empty flag describing occupancy after the current edge.
module serial_iot_sequencer_char_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       nonempty_next
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign full          = (count_q == FULL_COUNT);
    assign empty         = (count_q == '0);
    assign head          = mem_q[rd_ptr_q];
    assign do_pop_s      = pop & ~empty;
    // A pop frees the slot the same edge, so a push into a full FIFO is legal then.
    assign do_push_s     = push & (~full | do_pop_s);
    assign nonempty_next = (count_d != '0);

    // Next-state pointers, occupancy and storage.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/serial_iot_sequencer.sv
// Programmed-I/O scheduler for the KL8E-style console: issues one TTY IOT per
// IOT slot. Optional feature macro: SERIAL_ECHO_EN (echo received chars to TX).
module serial_iot_sequencer
    import serial_iot_sequencer_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [4:0] IOT_STATE   = F1,
    parameter logic [5:0] TX_DEV      = 6'o04,
    parameter logic [5:0] RX_DEV      = 6'o03,
    parameter int         STALL_POLLS = 4095
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  state,
    input  logic        skip,
    input  logic [0:7]  rx_bus,
    output logic [0:11] instruction,
    output logic [0:11] ac,
    input  logic [0:7]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [0:7]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        tx_stall
);

    localparam int          CW          = $clog2(STALL_POLLS + 1);
    localparam logic [CW-1:0] STALL_LIMIT = CW'(STALL_POLLS);

    logic [2:0]    op_q, op_d;
    logic [11:0]   instruction_q, instruction_d;
    logic [11:0]   ac_q, ac_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          tx_stall_q, tx_stall_d;
    logic [CW-1:0] poll_cnt_q, poll_cnt_d;

    logic          slot_s;
    logic          rx_open_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic [7:0]    fifo_wdata_s;
    logic [7:0]    fifo_head_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          fifo_nonempty_next_s;

    function automatic logic [11:0] op_iot_word(input logic [2:0] op);
        case (op)
            OP_PRIME: return iot_word(TX_DEV, IOT_FN_XFER);
            OP_TSF:   return iot_word(TX_DEV, IOT_FN_SKIP);
            OP_TLS:   return iot_word(TX_DEV, IOT_FN_XFER);
            OP_KSF:   return iot_word(RX_DEV, IOT_FN_SKIP);
            OP_KRB:   return iot_word(RX_DEV, IOT_FN_XFER);
            default:  return NOP_WORD;
        endcase
    endfunction

    assign slot_s     = (state == IOT_STATE);
    assign rx_open_s  = ~rx_valid_q | rx_ready;
    assign fifo_pop_s = slot_s & (op_q == OP_TLS);

`ifdef SERIAL_ECHO_EN
    logic krb_slot_s;

    // The echoed char owns the push port during a KRB slot; it is dropped if full.
    assign krb_slot_s   = slot_s & (op_q == OP_KRB);
    assign tx_ready     = ~fifo_full_s & ~krb_slot_s;
    assign fifo_push_s  = (krb_slot_s & ~fifo_full_s) | (tx_valid & tx_ready);
    assign fifo_wdata_s = krb_slot_s ? rx_bus : tx_data;
`else
    assign tx_ready     = ~fifo_full_s;
    assign fifo_push_s  = tx_valid & tx_ready;
    assign fifo_wdata_s = tx_data;
`endif

    serial_iot_sequencer_char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_char_fifo (
        .clock         (clock),
        .reset         (reset),
        .push          (fifo_push_s),
        .push_data     (fifo_wdata_s),
        .pop           (fifo_pop_s),
        .head          (fifo_head_s),
        .full          (fifo_full_s),
        .empty         (fifo_empty_s),
        .nonempty_next (fifo_nonempty_next_s)
    );

    // Op sequencing, rx holding register and stall accounting.
    always_comb begin
        op_d          = op_q;
        instruction_d = instruction_q;
        ac_d          = ac_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        poll_cnt_d    = poll_cnt_q;
        tx_stall_d    = tx_stall_q;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        if (slot_s) begin
            case (op_q)
                OP_PRIME: op_d = OP_NOP;
                OP_TSF: begin
                    if (skip) begin
                        op_d       = OP_TLS;
                        poll_cnt_d = '0;
                    end else begin
                        // Failed output poll hands the slot to the receiver if it can take a char.
                        op_d = rx_open_s ? OP_KSF : OP_TSF;
                        if (poll_cnt_q != STALL_LIMIT) begin
                            poll_cnt_d = poll_cnt_q + CW'(1);
                        end else begin
                            poll_cnt_d = poll_cnt_q;
                        end
                    end
                end
                OP_TLS: begin
                    if (rx_open_s) begin
                        op_d = OP_KSF;
                    end else begin
                        op_d = fifo_nonempty_next_s ? OP_TSF : OP_NOP;
                    end
                end
                OP_KSF: begin
                    if (skip) begin
                        op_d = OP_KRB;
                    end else begin
                        op_d = fifo_nonempty_next_s ? OP_TSF : OP_KSF;
                    end
                end
                OP_KRB: begin
                    rx_data_d  = rx_bus;
                    rx_valid_d = 1'b1;
                    op_d       = fifo_nonempty_next_s ? OP_TSF : OP_NOP;
                end
                OP_NOP: begin
                    if (fifo_nonempty_next_s) begin
                        op_d = OP_TSF;
                    end else begin
                        op_d = rx_open_s ? OP_KSF : OP_NOP;
                    end
                end
                default: op_d = OP_NOP;
            endcase
            instruction_d = op_iot_word(op_d);
            ac_d          = (op_d == OP_TLS) ? {4'b0000, fifo_head_s} : 12'o0000;
        end else begin
            op_d          = op_q;
            instruction_d = instruction_q;
            ac_d          = ac_q;
        end

        if (poll_cnt_d == STALL_LIMIT) begin
            tx_stall_d = 1'b1;
        end else begin
            tx_stall_d = tx_stall_q;
        end
    end

    // Sequencer and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q          <= OP_PRIME;
            instruction_q <= iot_word(TX_DEV, IOT_FN_XFER);
            ac_q          <= 12'o0000;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            poll_cnt_q    <= '0;
            tx_stall_q    <= 1'b0;
        end else begin
            op_q          <= op_d;
            instruction_q <= instruction_d;
            ac_q          <= ac_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            poll_cnt_q    <= poll_cnt_d;
            tx_stall_q    <= tx_stall_d;
        end
    end

    assign instruction = instruction_q;
    assign ac          = ac_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_stall    = tx_stall_q;

endmodule
